// File: rtl/pg_pkg.sv
// Shared Peres-gate definitions: default lane width plus the forward (PG) and
// inverse (PG^-1) bitwise transforms used by encoder, decoder and scoreboards.
package pg_pkg;

  localparam int PG_W = 8;

  function automatic logic [3*PG_W-1:0] pg_fwd(input logic [PG_W-1:0] a,
                                               input logic [PG_W-1:0] b,
                                               input logic [PG_W-1:0] c);
    return {a, a ^ b, (a & b) ^ c};
  endfunction

  function automatic logic [3*PG_W-1:0] pg_inv(input logic [PG_W-1:0] d,
                                               input logic [PG_W-1:0] e,
                                               input logic [PG_W-1:0] f);
    logic [PG_W-1:0] b;
    b = d ^ e;
    return {d, b, (d & b) ^ f};
  endfunction

endpackage

// File: rtl/pg_inv_stage.sv
// One valid/ready register slice carrying a PW-bit payload; accepts whenever it
// is empty or its content leaves in the same cycle, so it sustains 1 word/cycle.
module pg_inv_stage
  import pg_pkg::*;
#(
  parameter int PW = 3 * PG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [PW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [PW-1:0] dn_data
);

  logic load;

  assign up_ready = !dn_valid || dn_ready;
  assign load     = up_valid && up_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (load) begin
      dn_valid <= 1'b1;
      dn_data  <= up_data;
    end else if (dn_ready) begin
      dn_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pg_inv_pipe.sv
// Two-stage streaming inverse-Peres decoder (d,e,f) -> (a,b,c) with a wrapping
// output-word counter. Optional PG_ROUNDTRIP_CHECK_EN adds a sticky re-encode check.
module pg_inv_pipe
  import pg_pkg::*;
#(
  parameter int W     = PG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_d,
  input  logic [W-1:0]     in_e,
  input  logic [W-1:0]     in_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_a,
  output logic [W-1:0]     out_b,
  output logic [W-1:0]     out_c,
`ifdef PG_ROUNDTRIP_CHECK_EN
  output logic             chk_err,
`endif
  output logic [CNT_W-1:0] word_cnt
);

`ifdef PG_ROUNDTRIP_CHECK_EN
  // S1 also carries the original e so the check sees the true encoded word.
  localparam int S1_W = 4 * W;
  localparam int S2_W = 6 * W;
`else
  localparam int S1_W = 3 * W;
  localparam int S2_W = 3 * W;
`endif

  logic            s1_valid, s2_free;
  logic [S1_W-1:0] s1_din, s1_q;
  logic [S2_W-1:0] s2_din, s2_q;
  logic [W-1:0]    s1_a, s1_b, s1_f;

  // Stage 1 boundary: a = d, b = d ^ e, f passed through
`ifdef PG_ROUNDTRIP_CHECK_EN
  logic [W-1:0] s1_e;
  assign s1_din = {in_d, in_d ^ in_e, in_f, in_e};
  assign s1_e   = s1_q[W-1:0];
`else
  assign s1_din = {in_d, in_d ^ in_e, in_f};
`endif
  assign s1_a = s1_q[S1_W-1 -: W];
  assign s1_b = s1_q[S1_W-W-1 -: W];
  assign s1_f = s1_q[S1_W-2*W-1 -: W];

  pg_inv_stage #(.PW(S1_W)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .up_valid (in_valid),
    .up_ready (in_ready),
    .up_data  (s1_din),
    .dn_valid (s1_valid),
    .dn_ready (s2_free),
    .dn_data  (s1_q)
  );

  // Stage 2 boundary: c = (a & b) ^ f
`ifdef PG_ROUNDTRIP_CHECK_EN
  assign s2_din = {s1_a, s1_b, (s1_a & s1_b) ^ s1_f, s1_a, s1_e, s1_f};
`else
  assign s2_din = {s1_a, s1_b, (s1_a & s1_b) ^ s1_f};
`endif

  pg_inv_stage #(.PW(S2_W)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .up_valid (s1_valid),
    .up_ready (s2_free),
    .up_data  (s2_din),
    .dn_valid (out_valid),
    .dn_ready (out_ready),
    .dn_data  (s2_q)
  );

  assign out_a = s2_q[S2_W-1 -: W];
  assign out_b = s2_q[S2_W-W-1 -: W];
  assign out_c = s2_q[S2_W-2*W-1 -: W];

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (out_valid && out_ready) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

`ifdef PG_ROUNDTRIP_CHECK_EN
  logic [W-1:0] chk_d, chk_e, chk_f;
  logic         mism;

  assign chk_d = s2_q[3*W-1 -: W];
  assign chk_e = s2_q[2*W-1 -: W];
  assign chk_f = s2_q[W-1:0];
  assign mism  = (out_a != chk_d) || ((out_a ^ out_b) != chk_e) ||
                 (((out_a & out_b) ^ out_c) != chk_f);

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err <= 1'b0;
    end else if (out_valid && mism) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule
